// File: rtl/flag_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// flag_ctrl_pkg
// Shared definitions for the branch/flag control slice: the two-state flush
// FSM encoding and the bit positions of the NZCV flags inside a 4-bit vector.
// ---------------------------------------------------------------------------
package flag_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flag_state_e;

  // NZCV bit indices, vector order {N,Z,C,V}
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Flush counter width; FLUSH_CYCLES is limited to 1..7
  localparam int unsigned FLUSH_CNT_W = 3;

endpackage

// File: rtl/branch_flag_ctrl_if.sv
// ---------------------------------------------------------------------------
// branch_flag_ctrl_if
// Pipeline-side bundle between the Execute stage and the branch/flag control.
//   FlagsNext  : next NZCV from the condition unit
//   CondEx     : condition-pass for the instruction in Execute
//   BranchE    : instruction in Execute is a branch
//   ValidE     : Execute holds a real instruction
//   StallE     : Execute stalled this cycle
//   Flags      : architectural NZCV register
//   PCSrc      : one-cycle redirect pulse to Fetch
//   FlushD/E   : squash Decode / Execute registers
//   TakenCount : saturating count of taken branches
// master = pipeline driving Execute info, slave = branch_flag_ctrl.
// ---------------------------------------------------------------------------
interface branch_flag_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       FlagsNext;
  logic             CondEx;
  logic             BranchE;
  logic             ValidE;
  logic             StallE;
  logic [3:0]       Flags;
  logic             PCSrc;
  logic             FlushD;
  logic             FlushE;
  logic [CNT_W-1:0] TakenCount;

  modport master (
    output FlagsNext, CondEx, BranchE, ValidE, StallE,
    input  Flags, PCSrc, FlushD, FlushE, TakenCount
  );

  modport slave (
    input  FlagsNext, CondEx, BranchE, ValidE, StallE,
    output Flags, PCSrc, FlushD, FlushE, TakenCount
  );
endinterface

// File: rtl/branch_flag_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   reset : synchronous active-high clear
//   inc   : add one this cycle (ignored once saturated)
//   count : current value
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/branch_flag_ctrl.sv
// ---------------------------------------------------------------------------
// branch_flag_ctrl
// Owns the NZCV flags register and the taken-branch redirect/flush sequence.
// A taken branch in Execute produces a one-cycle PCSrc pulse and holds
// FlushD/FlushE for FLUSH_CYCLES cycles; while flushing, Execute contents are
// wrong-path and neither branch nor flag updates are honoured.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : branch_flag_ctrl_if.slave (Execute inputs, control outputs)
// ---------------------------------------------------------------------------
module branch_flag_ctrl
  import flag_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_flag_ctrl_if.slave    bus
);

  flag_state_e            r_state;
  logic [FLUSH_CNT_W-1:0] r_flush_cnt;
  logic [3:0]             r_flags;
  logic                   r_pcsrc;
  logic                   r_flush;

  logic w_idle;
  logic w_advance;
  logic w_taken;

  // Execute retires an instruction only when real, unstalled and not wrong-path
  assign w_idle    = (r_state == IDLE);
  assign w_advance = bus.ValidE & ~bus.StallE & w_idle;
  assign w_taken   = w_advance & bus.BranchE & bus.CondEx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent
  // simulation and mismatch synthesis.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_flush_cnt <= '0;
      r_flags     <= 4'b0000;
      r_pcsrc     <= 1'b0;
      r_flush     <= 1'b0;
    end else begin
      // A flag-setting taken branch also lands here, visible from T+1
      if (w_advance) begin
        r_flags <= bus.FlagsNext;
      end

      r_pcsrc <= w_taken;

      case (r_state)
        IDLE: begin
          if (w_taken) begin
            r_state     <= FLUSH;
            r_flush_cnt <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
            r_flush     <= 1'b1;
          end
        end
        FLUSH: begin
          // Stall is deliberately ignored: the flush always runs to completion
          if (r_flush_cnt == '0) begin
            r_state <= IDLE;
            r_flush <= 1'b0;
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  // Reset inside the counter already dominates a simultaneous taken event
  sat_counter #(
    .WIDTH (CNT_W)
  ) u_taken_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_taken),
    .count (bus.TakenCount)
  );

  assign bus.Flags  = r_flags;
  assign bus.PCSrc  = r_pcsrc;
  assign bus.FlushD = r_flush;
  assign bus.FlushE = r_flush;

endmodule

// File: tb/tb_branch_flag_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_flag_ctrl
// Two instances share one stimulus stream: A (FLUSH_CYCLES=2, CNT_W=16) and
// B (FLUSH_CYCLES=3, CNT_W=4). The reference model tracks, per instance, the
// cycle number of the last taken branch; flush/redirect outputs are derived
// from the distance to that cycle rather than from any state machine.
// ---------------------------------------------------------------------------
module tb_branch_flag_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_flag_ctrl_if #(.CNT_W(16)) bus_a ();
  branch_flag_ctrl_if #(.CNT_W(4))  bus_b ();

  branch_flag_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_a.slave)
  );

  branch_flag_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_b.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int       fc   [2] = '{2, 3};
  int       cmax [2] = '{65535, 15};
  int       m_last  [2];
  int       m_count [2];
  logic [3:0] m_flags [2];
  int       cyc;

  function automatic bit in_flush(int k, int c);
    return (c >= m_last[k] + 1) && (c <= m_last[k] + fc[k]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_last[k]  = -1000;
      m_count[k] = 0;
      m_flags[k] = 4'b0000;
    end
  endtask

  task automatic check_dut(input int k, input logic [3:0] f, input logic p,
                           input logic fd, input logic fe, input logic [15:0] cnt);
    bit exp_fl;
    exp_fl = in_flush(k, cyc);
    check($sformatf("c%0d_dut%0d_flags", cyc, k), 32'(f), 32'(m_flags[k]));
    check($sformatf("c%0d_dut%0d_pcsrc", cyc, k), 32'(p), 32'(cyc == m_last[k] + 1));
    check($sformatf("c%0d_dut%0d_flushd", cyc, k), 32'(fd), 32'(exp_fl));
    check($sformatf("c%0d_dut%0d_flushe", cyc, k), 32'(fe), 32'(exp_fl));
    check($sformatf("c%0d_dut%0d_count", cyc, k), 32'(cnt), 32'(m_count[k]));
  endtask

  // One clock: apply inputs, advance model across the edge, compare after it
  task automatic step(input logic r, input logic [3:0] fn, input logic ce,
                      input logic br, input logic v, input logic st);
    bit idle [2];
    rst = r;
    bus_a.FlagsNext = fn; bus_a.CondEx = ce; bus_a.BranchE = br;
    bus_a.ValidE = v;     bus_a.StallE = st;
    bus_b.FlagsNext = fn; bus_b.CondEx = ce; bus_b.BranchE = br;
    bus_b.ValidE = v;     bus_b.StallE = st;
    for (int k = 0; k < 2; k++) idle[k] = !in_flush(k, cyc);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (v && !st && idle[k]) begin
          m_flags[k] = fn;
          if (br && ce) begin
            m_last[k]  = cyc;
            m_count[k] = (m_count[k] < cmax[k]) ? m_count[k] + 1 : m_count[k];
          end
        end
      end
    end
    cyc++;
    #1;
    check_dut(0, bus_a.Flags, bus_a.PCSrc, bus_a.FlushD, bus_a.FlushE, bus_a.TakenCount);
    check_dut(1, bus_b.Flags, bus_b.PCSrc, bus_b.FlushD, bus_b.FlushE, {12'h000, bus_b.TakenCount});
  endtask

  initial begin
    cyc = 0;
    model_reset();

    // Reset state
    step(1, 4'h0, 0, 0, 0, 0);
    step(1, 4'h0, 0, 0, 0, 0);

    // Plain flag load
    step(0, 4'b0100, 0, 0, 1, 0);
    check("dir_flags_load", 32'(bus_a.Flags), 32'h4);
    check("dir_no_redirect", 32'(bus_a.PCSrc), 32'h0);

    // Stall holds flags
    step(0, 4'b0010, 0, 0, 1, 1);
    check("dir_stall_hold", 32'(bus_a.Flags), 32'h4);

    // Taken branch (cycle T) writing flags, then wrong-path branches in flush
    step(0, 4'b0011, 1, 1, 1, 0);
    check("dir_T1_pcsrc", 32'(bus_a.PCSrc), 32'h1);
    check("dir_T1_flush", 32'(bus_a.FlushD), 32'h1);
    check("dir_T1_count", 32'(bus_a.TakenCount), 32'h1);
    check("dir_T1_flags", 32'(bus_a.Flags), 32'h3);
    step(0, 4'b1111, 1, 1, 1, 0);
    check("dir_T2_pcsrc", 32'(bus_a.PCSrc), 32'h0);
    check("dir_T2_flush", 32'(bus_a.FlushE), 32'h1);
    check("dir_T2_flags", 32'(bus_a.Flags), 32'h3);
    step(0, 4'b1111, 1, 1, 1, 1);
    check("dir_T3_flush_off", 32'(bus_a.FlushD), 32'h0);
    check("dir_T3_count", 32'(bus_a.TakenCount), 32'h1);

    // Stall throughout a flush does not extend it
    step(0, 4'b1000, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 4'b0001, 1, 1, 1, 1);

    // Reset at T+1 of a flush
    step(0, 4'b0000, 0, 0, 0, 0);
    step(0, 4'b0110, 1, 1, 1, 0);
    step(1, 4'b0000, 0, 0, 0, 0);
    check("dir_rst_mid_flush", 32'(bus_a.FlushD), 32'h0);
    check("dir_rst_count", 32'(bus_a.TakenCount), 32'h0);

    // Reset dominates a simultaneous taken event
    step(1, 4'b1010, 1, 1, 1, 0);
    check("dir_rst_dominates", 32'(bus_a.PCSrc), 32'h0);

    // Saturation: 20 spaced taken branches, B must stick at 4'hF
    for (int i = 0; i < 20; i++) begin
      step(0, 4'(i), 1, 1, 1, 0);
      for (int j = 0; j < 4; j++) step(0, 4'h0, 0, 0, 0, 0);
    end
    check("dir_sat_b", 32'(bus_b.TakenCount), 32'hF);
    check("dir_nosat_a", 32'(bus_a.TakenCount), 32'd20);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(299) == 0),
           4'($urandom),
           ($urandom_range(99) < 60),
           ($urandom_range(99) < 30),
           ($urandom_range(99) < 80),
           ($urandom_range(99) < 20));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_flag_ctrl.md
BRANCH_FLAG_CTRL -- requirements
Module: branch_flag_ctrl

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 2, number of cycles FlushD/FlushE stay high after a taken branch (legal 1..7).
REQ-002 Parameter: CNT_W, default 16, width of the taken-branch counter.
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: FlagsNext  in  4  next NZCV from the condition unit, bit order {N,Z,C,V}.
REQ-006 Port: CondEx  in  1  condition-pass for the instruction in Execute.
REQ-007 Port: BranchE  in  1  instruction in Execute is a branch.
REQ-008 Port: ValidE  in  1  Execute holds a real instruction, not a bubble.
REQ-009 Port: StallE  in  1  Execute stalled this cycle.
REQ-010 Port: Flags  out  4  architectural NZCV register, fed back to the condition unit.
REQ-011 Port: PCSrc  out  1  one-cycle redirect pulse to Fetch.
REQ-012 Port: FlushD  out  1  squash the Decode register.
REQ-013 Port: FlushE  out  1  squash the Execute register.
REQ-014 Port: TakenCount  out  CNT_W  saturating count of taken branches.

Function
REQ-015 Flags register SHALL load FlagsNext on an edge where ValidE=1, StallE=0 and state=IDLE; otherwise it SHALL hold.
REQ-016 Taken event (cycle T) SHALL be BranchE & CondEx & ValidE & ~StallE & state=IDLE.
REQ-017 FSM states SHALL be IDLE and FLUSH only.
REQ-018 IDLE->FLUSH on a taken event; the flush counter loads FLUSH_CYCLES-1.
REQ-019 In FLUSH the counter decrements each cycle; FLUSH->IDLE when it is 0.
REQ-020 PCSrc SHALL be registered: high in cycle T+1 only, low otherwise.
REQ-021 FlushD and FlushE SHALL be registered: high for exactly FLUSH_CYCLES cycles, T+1 to T+FLUSH_CYCLES; low in IDLE.
REQ-022 In FLUSH, BranchE/CondEx SHALL be ignored (wrong-path); no new taken event, no flag update.
REQ-023 StallE SHALL NOT pause the FLUSH counter; flush dominates stall.
REQ-024 A taken branch that also writes flags SHALL update Flags at the end of cycle T, so the new value is visible from T+1.
REQ-025 TakenCount SHALL increment by 1 at the end of each taken-event cycle and saturate at all-ones without wrapping.
REQ-026 Back-to-back taken branches SHALL be impossible: the earliest next taken event is cycle T+FLUSH_CYCLES+1.

Reset
REQ-027 On reset=1 at an edge: Flags=4'b0000, state=IDLE, flush counter=0, PCSrc=FlushD=FlushE=0, TakenCount=0.
REQ-028 Reset mid-FLUSH SHALL abort the flush immediately; outputs are low from the next cycle.
REQ-029 Reset SHALL dominate a simultaneous taken event (no count, no redirect).

Structure
REQ-030 Shared package flag_ctrl_pkg SHALL hold the FSM state enum and the NZCV bit-index constants (N=3, Z=2, C=1, V=0).
REQ-031 The saturating counter SHALL be one sub-module, sat_counter (parameter width; ports: clk, reset, inc, count).
REQ-032 All other logic (FSM, flags register, output registers) SHALL be in branch_flag_ctrl.

Verification
REQ-033 After reset, ValidE=1, StallE=0, FlagsNext=4'b0100 -> Flags=4'b0100 next cycle; PCSrc=0.
REQ-034 Taken branch at T with FLUSH_CYCLES=2 -> PCSrc=1 at T+1 only; FlushD=FlushE=1 at T+1 and T+2; TakenCount=1.
REQ-035 During FLUSH, drive BranchE=CondEx=1 and FlagsNext=4'b1111 -> no second PCSrc pulse; Flags unchanged; TakenCount unchanged.
REQ-036 StallE=1 with FlagsNext=4'b0010 -> Flags holds. StallE=1 during FLUSH -> flush still ends at T+FLUSH_CYCLES.
REQ-037 Reset at T+1 of a flush -> FlushD=FlushE=PCSrc=0 at T+2; Flags=0; TakenCount=0.
REQ-038 CNT_W=4: 17 spaced taken branches -> TakenCount sticks at 4'hF.
